// File: rtl/mmd_divider_if.sv
// Bundles the modulator-facing controls and the divider outputs of mmd_divider.
// No valid/ready: en qualifies every edge; div_ctrl is only sampled on the edge
// that ends a terminal-count cycle; clr_flag is sampled on every edge.
interface mmd_divider_if #(
  parameter int W = 6
) ();
  logic         en;
  logic [W-1:0] div_ctrl;
  logic         clr_flag;
  logic         div_out;
  logic         div_pulse;
  logic [W-1:0] mod_cur;
  logic         clamp_flag;

  modport master (
    output en, div_ctrl, clr_flag,
    input  div_out, div_pulse, mod_cur, clamp_flag
  );

  modport slave (
    input  en, div_ctrl, clr_flag,
    output div_out, div_pulse, mod_cur, clamp_flag
  );
endinterface

// File: rtl/mmd_divider.sv
// Multi-modulus divider: counts the VCO clock down from M-1 to 0, reloading the
// (clamped) modulus at terminal count; emits a near-50% clock and a tc strobe.
module mmd_divider #(
  parameter int W       = 6,
  parameter int MIN_DIV = 16,
  parameter int MAX_DIV = 47,
  parameter int RST_DIV = 30
) (
  input  logic      clk,
  input  logic      rstn,
  mmd_divider_if.slave bus
);
  localparam logic [W-1:0] MIN_W = W'(MIN_DIV);
  localparam logic [W-1:0] MAX_W = W'(MAX_DIV);
  localparam logic [W-1:0] RST_W = W'(RST_DIV);
  localparam logic [W-1:0] ONE_W = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] mod_reg;
  logic [W-1:0] dc_c;
  logic [W-1:0] cnt_next;
  logic [W-1:0] mod_next;
  logic         tc;
  logic         clamped;
  logic         div_out_r;
  logic         div_pulse_r;
  logic         clamp_r;

  always_comb begin
    dc_c = bus.div_ctrl;
    if (bus.div_ctrl < MIN_W) begin
      dc_c = MIN_W;
    end else if (bus.div_ctrl > MAX_W) begin
      dc_c = MAX_W;
    end
    clamped  = (dc_c != bus.div_ctrl);
    tc       = (cnt == '0);
    cnt_next = cnt - ONE_W;
    mod_next = mod_reg;
    // Reload at terminal count so cnt never wraps below zero.
    if (tc) begin
      cnt_next = dc_c - ONE_W;
      mod_next = dc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt         <= RST_W - ONE_W;
      mod_reg     <= RST_W;
      div_out_r   <= 1'b1;
      div_pulse_r <= 1'b0;
      clamp_r     <= 1'b0;
    end else begin
      if (bus.en) begin
        cnt       <= cnt_next;
        mod_reg   <= mod_next;
        div_out_r <= (cnt_next >= (mod_next >> 1));
      end
      div_pulse_r <= bus.en && (cnt_next == '0);
      // A clamp event at this edge takes priority over a simultaneous clear.
      if (bus.en && tc && clamped) begin
        clamp_r <= 1'b1;
      end else if (bus.clr_flag) begin
        clamp_r <= 1'b0;
      end
    end
  end

  assign bus.div_out    = div_out_r;
  assign bus.div_pulse  = div_pulse_r;
  assign bus.mod_cur    = mod_reg;
  assign bus.clamp_flag = clamp_r;
endmodule
